// File: rtl/vm_patron.sv
// vm_patron: host-command sequencer for a vending machine model.
// Loads prices, feeds coins, issues buy/return and collects the 6-beat response.
module vm_patron (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [29:0] cmd_data,
   output logic        in_item_valid,
   output logic [4:0]  in_item_price,
   output logic        in_coin_valid,
   output logic [5:0]  in_coin,
   output logic [2:0]  in_buy_item,
   output logic        in_rtn_coin,
   input  logic [8:0]  out_monitor,
   input  logic        out_valid,
   input  logic [3:0]  out_consumer,
   input  logic [5:0]  out_sell_num,
   output logic        res_valid,
   output logic [2:0]  res_item,
   output logic [8:0]  res_change,
   output logic [35:0] res_sold,
   output logic        res_err,
   output logic        res_mismatch
);
   localparam logic [1:0] OP_PRICE = 2'b00;
   localparam logic [1:0] OP_COIN  = 2'b01;
   localparam logic [1:0] OP_RTN   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_PRICE, S_COIN, S_REQ, S_WAIT, S_COLLECT, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [29:0] data_q, data_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [8:0]  credit_q, credit_d;
   logic        err_q, err_d;
   logic        mism_q, mism_d;
   logic [23:0] con_q, con_d;
   logic [35:0] sold_q, sold_d;
   logic [2:0]  res_item_q, res_item_d;
   logic [8:0]  res_change_q, res_change_d;
   logic [35:0] res_sold_q, res_sold_d;
   logic        res_err_q, res_err_d;
   logic        res_mismatch_q, res_mismatch_d;
   logic [3:0]  beat;
   logic [2:0]  item;

   assign item = data_q[2:0];

   function automatic logic [8:0] sat_add(input logic [8:0] a, input logic [5:0] b);
      logic [9:0] s;
      s = {1'b0, a} + {4'd0, b};
      return s[9] ? 9'd511 : s[8:0];
   endfunction

   // Coin weights 50/20/10/5/1 as shift-add terms, wrapping in 9 bits.
   function automatic logic [8:0] change_of(input logic [23:0] c);
      logic [8:0] b2, b3, b4, b5, b6;
      b2 = {5'd0, c[7:4]};
      b3 = {5'd0, c[11:8]};
      b4 = {5'd0, c[15:12]};
      b5 = {5'd0, c[19:16]};
      b6 = {5'd0, c[23:20]};
      return (b2 << 5) + (b2 << 4) + (b2 << 1) + (b3 << 4) + (b3 << 2)
           + (b4 << 3) + (b4 << 1) + (b5 << 2) + b5 + b6;
   endfunction

   function automatic logic [4:0] price_of(input logic [29:0] d, input logic [3:0] k);
      case (k)
         4'd0:    return d[4:0];
         4'd1:    return d[9:5];
         4'd2:    return d[14:10];
         4'd3:    return d[19:15];
         4'd4:    return d[24:20];
         default: return d[29:25];
      endcase
   endfunction

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      data_d         = data_q;
      cnt_d          = cnt_q;
      credit_d       = credit_q;
      err_d          = err_q;
      mism_d         = mism_q;
      con_d          = con_q;
      sold_d         = sold_q;
      res_item_d     = res_item_q;
      res_change_d   = res_change_q;
      res_sold_d     = res_sold_q;
      res_err_d      = res_err_q;
      res_mismatch_d = res_mismatch_q;
      beat           = 4'd0;
      cmd_ready      = 1'b0;
      in_item_valid  = 1'b0;
      in_item_price  = 5'd0;
      in_coin_valid  = 1'b0;
      in_coin        = 6'd0;
      in_buy_item    = 3'd0;
      in_rtn_coin    = 1'b0;
      res_valid      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               cnt_d  = 4'd0;
               case (cmd_op)
                  OP_PRICE: begin
                     state_d  = S_PRICE;
                     credit_d = 9'd0;
                  end
                  OP_COIN: state_d = S_COIN;
                  default: state_d = S_REQ;
               endcase
            end
         end
         S_PRICE: begin
            in_item_valid = 1'b1;
            in_item_price = price_of(data_q, cnt_q);
            cnt_d         = cnt_q + 4'd1;
            if (cnt_q == 4'd5) state_d = S_IDLE;
         end
         S_COIN: begin
            in_coin_valid = 1'b1;
            in_coin       = data_q[5:0];
            credit_d      = sat_add(credit_q, data_q[5:0]);
            state_d       = S_IDLE;
         end
         S_REQ: begin
            mism_d  = (out_monitor != credit_q);
            con_d   = 24'd0;
            sold_d  = 36'd0;
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            state_d = S_WAIT;
            if (op_q == OP_RTN) begin
               in_rtn_coin = 1'b1;
            end else if (item == 3'd0 || item == 3'd7) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               in_buy_item = item;
            end
         end
         S_WAIT: begin
            if (out_valid) begin
               beat    = 4'd1;
               cnt_d   = 4'd1;
               state_d = S_COLLECT;
            end else if (cnt_q == 4'd15) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_COLLECT: begin
            // cnt_q holds the number of beats already captured.
            if (out_valid) begin
               beat  = cnt_q + 4'd1;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd5) state_d = S_DONE;
            end else begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            credit_d  = 9'd0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      for (int k = 1; k <= 6; k++) begin
         if (beat == k[3:0]) begin
            con_d[4*k-4 +: 4]  = out_consumer;
            sold_d[6*k-6 +: 6] = out_sell_num;
         end
      end
      // Results are frozen on DONE entry so they are stable while res_valid is high.
      if (state_d == S_DONE) begin
         res_item_d     = con_d[2:0];
         res_change_d   = err_d ? 9'd0 : change_of(con_d);
         res_sold_d     = sold_d;
         res_err_d      = err_d;
         res_mismatch_d = mism_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         op_q           <= 2'd0;
         cnt_q          <= 4'd0;
         credit_q       <= 9'd0;
         err_q          <= 1'b0;
         mism_q         <= 1'b0;
         res_item_q     <= 3'd0;
         res_change_q   <= 9'd0;
         res_sold_q     <= 36'd0;
         res_err_q      <= 1'b0;
         res_mismatch_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         cnt_q          <= cnt_d;
         credit_q       <= credit_d;
         err_q          <= err_d;
         mism_q         <= mism_d;
         res_item_q     <= res_item_d;
         res_change_q   <= res_change_d;
         res_sold_q     <= res_sold_d;
         res_err_q      <= res_err_d;
         res_mismatch_q <= res_mismatch_d;
      end
   end

   // Payload registers are always written before they are read, so they carry no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      con_q  <= con_d;
      sold_q <= sold_d;
   end

   assign res_item     = res_item_q;
   assign res_change   = res_change_q;
   assign res_sold     = res_sold_q;
   assign res_err      = res_err_q;
   assign res_mismatch = res_mismatch_q;
endmodule

// File: doc/vm_patron.md
VM_PATRON -- requirements
Module: vm_patron

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; the ports are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd_valid  input  1  host command strobe.
REQ-005 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  input  2  00 PRICE, 01 COIN, 10 BUY, 11 RTN.
REQ-007 cmd_data  input  30  PRICE: item k price at [5k-1:5k-5], k=1..6; COIN: [5:0] coin value; BUY: [2:0] item number.
REQ-008 in_item_valid, in_item_price[4:0]  output  1, 5  price-load drive to the vending machine.
REQ-009 in_coin_valid, in_coin[5:0]  output  1, 6  coin drive.
REQ-010 in_buy_item[2:0], in_rtn_coin  output  3, 1  buy/return request drive.
REQ-011 out_monitor[8:0], out_valid, out_consumer[3:0], out_sell_num[5:0]  input  9, 1, 4, 6  vending machine response.
REQ-012 res_valid  output  1  one-cycle pulse carrying a BUY/RTN result.
REQ-013 res_item[2:0], res_change[8:0], res_sold[35:0], res_err, res_mismatch  output  result fields; res_sold holds item k count at [6k-1:6k-6].

Function
REQ-014 The block SHALL implement the states IDLE, PRICE, COIN, REQ, WAIT, COLLECT and DONE.
REQ-015 IDLE -> PRICE, COIN or REQ on command acceptance, selected by cmd_op; the command is captured in a register at acceptance.
REQ-016 PRICE: 6 consecutive cycles, in_item_valid=1, in_item_price = item 1..6 price in order, then IDLE; the credit register clears at PRICE entry.
REQ-017 COIN: 1 cycle, in_coin_valid=1, in_coin = captured value; credit = credit + coin, 9-bit saturating at 511; then IDLE.
REQ-018 REQ: 1 cycle driving in_buy_item = item (BUY) or in_rtn_coin=1 (RTN, in_buy_item=0); then WAIT.
REQ-019 In REQ, res_mismatch is latched as (out_monitor != credit).
REQ-020 A BUY with item 0 or 7 SHALL skip the vending machine drive and go directly to DONE with res_err=1 and res_change=0.
REQ-021 WAIT: on out_valid=1 -> COLLECT; that cycle is captured as beat 1. With no out_valid for 16 cycles -> DONE with res_err=1 and res_change=0.
REQ-022 COLLECT captures beats 1..6 of out_consumer and out_sell_num on consecutive cycles.
REQ-023 If out_valid drops before beat 6, the block SHALL go to DONE with res_err=1.
REQ-024 res_item = beat1[2:0].
REQ-025 res_change = 50*b2 + 20*b3 + 10*b4 + 5*b5 + b6, computed in 9 bits via shift-add with no multiplier, wrapping mod 512.
REQ-026 res_sold item k = out_sell_num at beat k.
REQ-027 DONE: res_valid=1 for exactly 1 cycle, credit cleared, then IDLE; the res_* fields hold their value until the next DONE.
REQ-028 All vending machine drive outputs SHALL be 0 in every cycle not listed above.
REQ-029 out_valid received in IDLE, PRICE, COIN or REQ SHALL be ignored.
REQ-030 cmd_valid while cmd_ready=0 SHALL be ignored, with no queuing.
REQ-031 Latency: BUY/RTN acceptance to res_valid = 1 (REQ) + WAIT cycles + 6 (COLLECT) + 1 cycles.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, credit=0, all outputs 0 except cmd_ready=1, and all res_* fields 0.
REQ-033 Reset asserted mid-PRICE or mid-COLLECT SHALL abort with no res_valid; operation resumes in IDLE after release.

Verification
REQ-034 PRICE {1:5, 2:13, 3:20, 4:7, 5:30, 6:31} -> in_item_valid high for 6 cycles, prices 5, 13, 20, 7, 30, 31 in order, cmd_ready low throughout.
REQ-035 COIN 50, COIN 10, BUY 2; responder returns beats {2, 0, 2, 0, 1, 2} and sells {0, 1, 0, 0, 0, 0} -> res_item=2, res_change=47, res_sold item2=1, res_err=0, res_mismatch=0.
REQ-036 COIN 20, RTN; beats {0, 0, 1, 0, 0, 0} -> res_item=0, res_change=20.
REQ-037 BUY 7 -> no in_buy_item drive, res_err=1 two cycles after acceptance.
REQ-038 BUY 1 with out_valid never asserted -> res_err=1 after 16 WAIT cycles; out_valid dropping at beat 4 -> res_err=1.
REQ-039 COIN 10 with out_monitor forced to 5 at REQ -> res_mismatch=1; rst_n pulsed during COLLECT -> no res_valid, cmd_ready=1.
